// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller.
// State encoding plus RAM data and wait-counter widths.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    ACK
  } mem_state_t;

  localparam int unsigned RAM_WIDTH  = 32;
  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/data_mem_ctrl.sv
// M-stage data-memory controller: one request at a time, range and
// alignment check, wait-state sequencing, single-cycle ack pulse.
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS = 8,
  parameter int unsigned WAIT_CYCLES   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_req_M,
  input  logic                     mem_write_M,
  input  logic [31:0]              alu_out_M,
  input  logic [RAM_WIDTH-1:0]     write_data_M,
  output logic [RAM_WIDTH-1:0]     read_data_M,
  output logic                     data_mem_ack_M,
  output logic                     mem_err_M,
  output logic                     ram_wr_en,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]     ram_data_in,
  input  logic [RAM_WIDTH-1:0]     ram_mem_out
);

  mem_state_t               state_q, state_d;
  logic [WAIT_CNT_W-1:0]    cnt_q, cnt_d;
  logic                     wr_q, wr_d;
  logic                     err_q, err_d;
  logic                     merr_q, merr_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0]     wdata_q, wdata_d;
  logic [RAM_WIDTH-1:0]     rdata_q, rdata_d;
  logic                     bad_addr;

  assign bad_addr = (alu_out_M[1:0] != 2'b00) ||
                    ((alu_out_M >> (RAM_ADDR_BITS + 2)) != 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req_M) begin
          wr_d    = mem_write_M;
          addr_d  = alu_out_M[RAM_ADDR_BITS+1:2];
          wdata_d = write_data_M;
          err_d   = bad_addr;
          if (bad_addr) begin
            rdata_d = '0;
            state_d = ACK;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (!wr_q) rdata_d = ram_mem_out;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Error flag is only exposed while the ack pulse is up.
  assign merr_d = (state_d == ACK) && err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      merr_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      merr_q  <= merr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_wr_en      = (state_q == ACCESS) && wr_q && !reset;
  assign ram_addr       = addr_q;
  assign ram_data_in    = wdata_q;
  assign data_mem_ack_M = (state_q == ACK);
  assign mem_err_M      = merr_q;
  assign read_data_M    = rdata_q;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory controller between the pipeline's M stage and the single-port synchronous `memory` RAM (8-bit word address, 32-bit data, 1-cycle registered read). It accepts one load/store request at a time from the M stage and checks alignment and range. It sequences the RAM access, absorbs a configurable number of wait states, and returns read data with a one-cycle `data_mem_ack_M` pulse. The pipeline stalls M while the ack is low.

## Interface
- `RAM_ADDR_BITS`, 8: RAM word-address width.
- `WAIT_CYCLES`, 0: extra wait states inserted before ack (0..15).
- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_req_M` in 1: M-stage access request; held stable until ack.
- `mem_write_M` in 1: 1 = store, 0 = load; held with request.
- `alu_out_M` in 32: byte address.
- `write_data_M` in 32: store data.
- `read_data_M` out 32: load data; valid in the ack cycle.
- `data_mem_ack_M` out 1: single-cycle completion pulse.
- `mem_err_M` out 1: valid with ack; 1 = misaligned or out-of-range, no RAM access done.
- `ram_wr_en` out 1: to RAM `wr_en`.
- `ram_addr` out RAM_ADDR_BITS: to RAM `addr`.
- `ram_data_in` out 32: to RAM `data_in`.
- `ram_mem_out` in 32: from RAM `mem_out`.

## Operation
- States are IDLE, ACCESS, WAIT, and ACK.
- IDLE
  - On `mem_req_M`=1, latch write flag, word address `alu_out_M[RAM_ADDR_BITS+1:2]` and write data.
  - If `alu_out_M[1:0]`≠0 or `alu_out_M[31:RAM_ADDR_BITS+2]`≠0, set error flag and go to ACK.
  - Otherwise go to ACCESS.
- ACCESS
  - Lasts one cycle.
  - `ram_addr` and `ram_data_in` are driven from latches.
  - `ram_wr_en` = latched write flag AND NOT `reset`; this is the only cycle it can be 1.
  - Go to WAIT and load the wait counter with `WAIT_CYCLES`.
- WAIT
  - `ram_addr` is held and `ram_wr_en`=0, so the RAM re-reads the same word every cycle.
  - Counter decrements each cycle.
  - When the counter is 0: for a load, `read_data_M` ← `ram_mem_out`; go to ACK.
- ACK
  - `data_mem_ack_M`=1 for exactly one cycle.
  - `mem_err_M` = latched error flag.
  - Go to IDLE. `mem_req_M` is ignored in this cycle.
- `read_data_M` keeps its previous value on store acks. It is forced to 0 on error acks.
- `mem_err_M` is 0 whenever ack is 0.
- Requests are sampled only in IDLE. A request seen in the cycle after ACK is a new access.
- `ram_addr` and `ram_data_in` hold their last latched values in IDLE and ACK.

## Timing
- Reset values:
  - State = IDLE; counter = 0.
  - `read_data_M`=0, `data_mem_ack_M`=0, `mem_err_M`=0.
  - `ram_wr_en`=0, `ram_addr`=0, `ram_data_in`=0.
- Latency is counted from the IDLE cycle with the request as cycle 0.
  - Valid access: ACCESS at cycle 1, WAIT at cycles 2..2+WAIT_CYCLES, ack at cycle 3+WAIT_CYCLES. With WAIT_CYCLES=0, ack is at cycle 3.
  - Error access: ack at cycle 1; `ram_wr_en` is never asserted.
- Back-to-back requests: minimum spacing between acks is 4+WAIT_CYCLES cycles (IDLE cycle included).
- Reset mid-operation:
  - The next edge returns to IDLE and no ack is issued for the aborted request.
  - Reset asserted during ACCESS suppresses the RAM write in that same cycle.
  - A write already committed in an earlier ACCESS cycle is not undone.
- `ram_wr_en` and `data_mem_ack_M` are decoded from the state register. `read_data_M` and `mem_err_M` are registered.

## Structure
- Package `mem_ctrl_pkg` contains:
  - state enum `mem_state_t` {IDLE, ACCESS, WAIT, ACK};
  - `RAM_WIDTH`=32;
  - `WAIT_CNT_W`=4.
- No sub-module; a single FSM plus latches.
- The RAM is instantiated beside this block at the next level up, not inside it.

## Test plan
- Reset, then store 0x1234_5678 to 0x0000_0010, WAIT_CYCLES=0:
  - `ram_wr_en` is high only at cycle 1, with `ram_addr`=4.
  - Ack at cycle 3; `mem_err_M`=0.
- Load from 0x0000_0010 after that store: ack at cycle 3 with `read_data_M`=0x1234_5678.
- Misaligned load at 0x0000_0013:
  - Ack at cycle 1 with `mem_err_M`=1 and `read_data_M`=0.
  - No RAM write occurs.
- Out-of-range store to 0x0000_0400: ack at cycle 1 with `mem_err_M`=1; the RAM word at address 0 is unchanged.
- WAIT_CYCLES=3, load 0x0000_03FC (word 255):
  - Ack at cycle 6 with correct data.
  - Ack stays low from cycle 0 to cycle 5.
- Reset asserted in the ACCESS cycle of a store to 0x20: no write reaches the RAM, no ack is issued, and all outputs return to their reset values on the next cycle.
